execution_result_arbiter: RTL and testbench

Collects the four result streams leaving the execution unit (ALU, BMU, MUL, DIV) and serialises them into a single writeback channel toward the reorder buffer. ALU, BMU, MUL and DIV can complete in the same cycle, and MUL cannot be stalled once issued. Each unit therefore gets its own result FIFO. A round-robin arbiter drains the FIFOs into a registered valid/ready output. A watermark stall goes back to issue so no FIFO ever overflows in normal operation.

---
 rtl/execution_result_arbiter_if.sv | 42 ++++
 rtl/execution_result_arbiter.sv | 151 +++++++++++++++
 tb/tb_execution_result_arbiter.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/execution_result_arbiter_if.sv
// Result streams from the four execution units plus the serialised writeback
// channel toward the reorder buffer.
interface execution_result_arbiter_if #(
    parameter int  XLEN           = 32,
    parameter type instr_packet_t = logic [31:0]
);
    logic [XLEN-1:0] alu_result_i;
    logic [XLEN-1:0] bmu_result_i;
    logic [XLEN-1:0] mul_result_i;
    logic [XLEN-1:0] div_result_i;
    instr_packet_t   alu_instr_packet_i;
    instr_packet_t   bmu_instr_packet_i;
    instr_packet_t   mul_instr_packet_i;
    instr_packet_t   div_instr_packet_i;
    logic            alu_valid_i;
    logic            bmu_valid_i;
    logic            mul_valid_i;
    logic            div_valid_i;

    logic [XLEN-1:0] result_o;
    instr_packet_t   instr_packet_o;
    logic            valid_o;
    logic            writeback_ready_i;
    logic            stall_o;
    logic            overflow_o;

    modport slave (
        input  alu_result_i, bmu_result_i, mul_result_i, div_result_i,
        input  alu_instr_packet_i, bmu_instr_packet_i, mul_instr_packet_i, div_instr_packet_i,
        input  alu_valid_i, bmu_valid_i, mul_valid_i, div_valid_i,
        input  writeback_ready_i,
        output result_o, instr_packet_o, valid_o, stall_o, overflow_o
    );

    modport master (
        output alu_result_i, bmu_result_i, mul_result_i, div_result_i,
        output alu_instr_packet_i, bmu_instr_packet_i, mul_instr_packet_i, div_instr_packet_i,
        output alu_valid_i, bmu_valid_i, mul_valid_i, div_valid_i,
        output writeback_ready_i,
        input  result_o, instr_packet_o, valid_o, stall_o, overflow_o
    );
endinterface

// File: rtl/execution_result_arbiter.sv
// Per-unit result FIFOs drained round-robin into one registered valid/ready
// writeback channel, with a watermark stall back to issue.
module execution_result_arbiter #(
    parameter int  XLEN           = 32,
    parameter type instr_packet_t = logic [31:0],
    parameter int  FIFO_DEPTH     = 16,
    parameter int  STALL_MARGIN   = 10
) (
    input  logic                             clk_i,
    input  logic                             rst_n_i,
    input  logic                             clk_en_i,
    input  logic                             flush_i,
    execution_result_arbiter_if.slave        wb
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT  = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] STALL_CNT = CW'(FIFO_DEPTH - STALL_MARGIN);

    typedef struct packed {
        logic [XLEN-1:0] result;
        instr_packet_t   packet;
    } entry_t;

    entry_t          in_entry [4];
    logic [3:0]      in_vld;
    entry_t          mem      [4][FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr   [4];
    logic [PW-1:0]   rd_ptr   [4];
    logic [CW-1:0]   count    [4];
    logic [3:0]      full;
    logic [3:0]      nonempty;
    logic [3:0]      push;
    logic [3:0]      pop;
    logic            load;
    logic            ovf_set;
    logic            stall;
    logic            found;
    logic [1:0]      grant;
    logic [1:0]      last_grant;
    entry_t          head;
    entry_t          out_p1;
    logic            vld_p1;
    logic            overflow_q;

    // Lowest offset from last_grant+1 wins; offset 4 (last_grant itself) has least priority.
    function automatic logic [2:0] rr_pick(input logic [1:0] lg, input logic [3:0] ne);
        logic [2:0] r;
        logic [1:0] idx;
        r = 3'b000;
        for (int k = 4; k >= 1; k--) begin
            idx = lg + 2'(k);
            if (ne[idx]) r = {1'b1, idx};
        end
        return r;
    endfunction

    assign in_vld = {wb.div_valid_i, wb.mul_valid_i, wb.bmu_valid_i, wb.alu_valid_i};

    always_comb begin
        in_entry[0] = '{result: wb.alu_result_i, packet: wb.alu_instr_packet_i};
        in_entry[1] = '{result: wb.bmu_result_i, packet: wb.bmu_instr_packet_i};
        in_entry[2] = '{result: wb.mul_result_i, packet: wb.mul_instr_packet_i};
        in_entry[3] = '{result: wb.div_result_i, packet: wb.div_instr_packet_i};
    end

    always_comb begin
        full     = '0;
        nonempty = '0;
        stall    = 1'b0;
        for (int i = 0; i < 4; i++) begin
            full[i]     = (count[i] == FULL_CNT);
            nonempty[i] = (count[i] != '0);
            if (count[i] >= STALL_CNT) stall = 1'b1;
        end
    end

    assign {found, grant} = rr_pick(last_grant, nonempty);
    assign head           = mem[grant][rd_ptr[grant]];
    assign load           = clk_en_i && (!vld_p1 || wb.writeback_ready_i);

    always_comb begin
        push    = '0;
        pop     = '0;
        ovf_set = 1'b0;
        for (int i = 0; i < 4; i++) begin
            push[i] = clk_en_i && !flush_i && in_vld[i] && !full[i];
            pop[i]  = load && !flush_i && found && (grant == 2'(i));
            if (clk_en_i && !flush_i && in_vld[i] && full[i]) ovf_set = 1'b1;
        end
    end

    // p0: FIFO pointers and occupancy
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < 4; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
                count[i]  <= '0;
            end
        end else if (clk_en_i) begin
            for (int i = 0; i < 4; i++) begin
                if (flush_i) begin
                    wr_ptr[i] <= '0;
                    rd_ptr[i] <= '0;
                    count[i]  <= '0;
                end else begin
                    if (push[i]) wr_ptr[i] <= wr_ptr[i] + 1'b1;
                    if (pop[i])  rd_ptr[i] <= rd_ptr[i] + 1'b1;
                    count[i] <= count[i] + CW'(push[i]) - CW'(pop[i]);
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        for (int i = 0; i < 4; i++) begin
            if (push[i]) mem[i][wr_ptr[i]] <= in_entry[i];
        end
    end

    // p1: registered writeback output and arbitration state
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            vld_p1     <= 1'b0;
            out_p1     <= '0;
            last_grant <= 2'd3;
            overflow_q <= 1'b0;
        end else if (clk_en_i) begin
            if (ovf_set) overflow_q <= 1'b1;
            if (flush_i) begin
                vld_p1     <= 1'b0;
                last_grant <= 2'd3;
            end else if (load) begin
                if (found) begin
                    vld_p1     <= 1'b1;
                    out_p1     <= head;
                    last_grant <= grant;
                end else begin
                    vld_p1     <= 1'b0;
                end
            end
        end
    end

    assign wb.result_o       = out_p1.result;
    assign wb.instr_packet_o = out_p1.packet;
    assign wb.valid_o        = vld_p1;
    assign wb.stall_o        = stall;
    assign wb.overflow_o     = overflow_q;
endmodule

// File: tb/tb_execution_result_arbiter.sv
// Directed scoreboard bench for execution_result_arbiter.
`timescale 1ns/1ps
module tb_execution_result_arbiter;
    localparam int XLEN = 32;
    typedef logic [15:0] pkt_t;
    typedef logic [XLEN+15:0] exp_t;

    logic clk_i = 1'b0;
    logic rst_n_i;
    logic clk_en_i;
    logic flush_i;

    always #5 clk_i = ~clk_i;

    execution_result_arbiter_if #(.XLEN(XLEN), .instr_packet_t(pkt_t)) wb ();

    execution_result_arbiter #(
        .XLEN(XLEN), .instr_packet_t(pkt_t), .FIFO_DEPTH(16), .STALL_MARGIN(10)
    ) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .clk_en_i(clk_en_i), .flush_i(flush_i), .wb(wb)
    );

    int   n_cmp = 0;
    int   n_err = 0;
    exp_t exp_q[$];

    function automatic pkt_t pkt_of(input int u, input logic [31:0] d);
        pkt_t p;
        p = {2'(u), d[13:0]};
        return p;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [3:0] v, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] m, input logic [31:0] d);
        wb.alu_valid_i = v[0]; wb.alu_result_i = a; wb.alu_instr_packet_i = pkt_of(0, a);
        wb.bmu_valid_i = v[1]; wb.bmu_result_i = b; wb.bmu_instr_packet_i = pkt_of(1, b);
        wb.mul_valid_i = v[2]; wb.mul_result_i = m; wb.mul_instr_packet_i = pkt_of(2, m);
        wb.div_valid_i = v[3]; wb.div_result_i = d; wb.div_instr_packet_i = pkt_of(3, d);
    endtask

    task automatic idle();
        drive(4'b0000, 32'h0, 32'h0, 32'h0, 32'h0);
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic expect_out(input int u, input logic [31:0] d);
        exp_q.push_back({d, pkt_of(u, d)});
    endtask

    task automatic do_flush();
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
    endtask

    task automatic drain(input string name, input int limit);
        for (int c = 0; c < limit && exp_q.size() != 0; c++) step();
        check(name, 64'(exp_q.size()), 64'd0);
    endtask

    // Scoreboard monitor: every accepted transfer must match the queue head.
    always @(negedge clk_i) begin
        if (rst_n_i && clk_en_i && !flush_i && wb.valid_o && wb.writeback_ready_i) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_output: got %0h expected none", {wb.result_o, wb.instr_packet_o});
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if ({wb.result_o, wb.instr_packet_o} !== e) begin
                    n_err++;
                    $display("FAIL wb_data: got %0h expected %0h", {wb.result_o, wb.instr_packet_o}, e);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n_i = 1'b0;
        clk_en_i = 1'b1;
        flush_i = 1'b0;
        wb.writeback_ready_i = 1'b1;
        idle();
        repeat (2) step();
        check("rst_valid",    64'(wb.valid_o),        64'd0);
        check("rst_result",   64'(wb.result_o),       64'd0);
        check("rst_packet",   64'(wb.instr_packet_o), 64'd0);
        check("rst_stall",    64'(wb.stall_o),        64'd0);
        check("rst_overflow", 64'(wb.overflow_o),     64'd0);
        rst_n_i = 1'b1;
        step();

        // Single ALU push: two-edge latency
        drive(4'b0001, 32'hAA, 32'h0, 32'h0, 32'h0);
        expect_out(0, 32'hAA);
        step();
        idle();
        check("lat_edge_n_valid", 64'(wb.valid_o), 64'd0);
        step();
        check("lat_valid",  64'(wb.valid_o),  64'd1);
        check("lat_result", 64'(wb.result_o), 64'hAA);
        step();
        check("lat_after_valid", 64'(wb.valid_o), 64'd0);
        check("lat_q_empty", 64'(exp_q.size()), 64'd0);

        // Four simultaneous pushes drain ALU, BMU, MUL, DIV back to back
        do_flush();
        drive(4'b1111, 32'd1, 32'd2, 32'd3, 32'd4);
        expect_out(0, 32'd1); expect_out(1, 32'd2); expect_out(2, 32'd3); expect_out(3, 32'd4);
        step();
        idle();
        for (int i = 0; i < 4; i++) begin
            step();
            check("quad_valid", 64'(wb.valid_o), 64'd1);
            check("quad_stall", 64'(wb.stall_o), 64'd0);
        end
        step();
        check("quad_end_valid", 64'(wb.valid_o), 64'd0);
        check("quad_q_empty", 64'(exp_q.size()), 64'd0);

        // Fairness: ALU every cycle, DIV once
        do_flush();
        expect_out(0, 32'h100); expect_out(0, 32'h101); expect_out(3, 32'hD0);
        expect_out(0, 32'h102); expect_out(0, 32'h103); expect_out(0, 32'h104); expect_out(0, 32'h105);
        for (int e = 0; e < 6; e++) begin
            drive((e == 2) ? 4'b1001 : 4'b0001, 32'h100 + 32'(e), 32'h0, 32'h0, 32'hD0);
            step();
        end
        idle();
        drain("fair_drain", 20);

        // Backpressure: MUL pushes 8 while ready is low
        do_flush();
        wb.writeback_ready_i = 1'b0;
        for (int e = 0; e < 8; e++) begin
            drive(4'b0100, 32'h0, 32'h0, 32'h300 + 32'(e), 32'h0);
            expect_out(2, 32'h300 + 32'(e));
            step();
            if (e == 1) check("bp_first_result", 64'(wb.result_o), 64'h300);
            if (e == 5) check("bp_stall_low", 64'(wb.stall_o), 64'd0);
            if (e == 6) check("bp_stall_high", 64'(wb.stall_o), 64'd1);
        end
        idle();
        repeat (12) step();
        check("bp_hold_valid",  64'(wb.valid_o),        64'd1);
        check("bp_hold_result", 64'(wb.result_o),       64'h300);
        check("bp_hold_packet", 64'(wb.instr_packet_o), 64'(pkt_of(2, 32'h300)));
        check("bp_hold_stall",  64'(wb.stall_o),        64'd1);
        wb.writeback_ready_i = 1'b1;
        drain("bp_drain", 20);
        step();
        check("bp_overflow", 64'(wb.overflow_o), 64'd0);
        check("bp_stall_released", 64'(wb.stall_o), 64'd0);

        // Overflow: fill DIV, then one extra push is dropped
        do_flush();
        wb.writeback_ready_i = 1'b0;
        for (int e = 0; e < 17; e++) begin
            drive(4'b1000, 32'h0, 32'h0, 32'h0, 32'h500 + 32'(e));
            expect_out(3, 32'h500 + 32'(e));
            step();
        end
        check("ovf_before", 64'(wb.overflow_o), 64'd0);
        check("ovf_full_stall", 64'(wb.stall_o), 64'd1);
        drive(4'b1000, 32'h0, 32'h0, 32'h0, 32'h5FF);
        step();
        idle();
        check("ovf_set", 64'(wb.overflow_o), 64'd1);
        wb.writeback_ready_i = 1'b1;
        drain("ovf_drain", 40);
        step();
        check("ovf_after_drain_valid", 64'(wb.valid_o), 64'd0);
        do_flush();
        check("ovf_sticky_flush", 64'(wb.overflow_o), 64'd1);

        // Flush with 5 entries buffered and a same-cycle MUL push
        wb.writeback_ready_i = 1'b0;
        drive(4'b1111, 32'h601, 32'h602, 32'h603, 32'h604);
        step();
        drive(4'b0001, 32'h605, 32'h0, 32'h0, 32'h0);
        step();
        check("fl_pre_valid", 64'(wb.valid_o), 64'd1);
        flush_i = 1'b1;
        drive(4'b0100, 32'h0, 32'h0, 32'h606, 32'h0);
        step();
        flush_i = 1'b0;
        idle();
        check("fl_valid", 64'(wb.valid_o), 64'd0);
        check("fl_stall", 64'(wb.stall_o), 64'd0);
        wb.writeback_ready_i = 1'b1;
        drive(4'b0001, 32'h777, 32'h0, 32'h0, 32'h0);
        expect_out(0, 32'h777);
        step();
        idle();
        step();
        check("fl_next_result", 64'(wb.result_o), 64'h777);
        drain("fl_drain", 5);
        repeat (3) step();
        check("fl_no_leftovers", 64'(wb.valid_o), 64'd0);

        // Clock enable low: push ignored
        clk_en_i = 1'b0;
        drive(4'b0001, 32'h888, 32'h0, 32'h0, 32'h0);
        step();
        idle();
        clk_en_i = 1'b1;
        repeat (3) step();
        check("clken_ignored", 64'(wb.valid_o), 64'd0);

        // Asynchronous reset mid-operation
        wb.writeback_ready_i = 1'b0;
        drive(4'b1001, 32'h999, 32'h0, 32'h0, 32'h99A);
        step();
        idle();
        step();
        check("arst_pre_valid", 64'(wb.valid_o), 64'd1);
        #2;
        rst_n_i = 1'b0;
        #1;
        check("arst_valid",    64'(wb.valid_o),    64'd0);
        check("arst_result",   64'(wb.result_o),   64'd0);
        check("arst_overflow", 64'(wb.overflow_o), 64'd0);
        check("arst_stall",    64'(wb.stall_o),    64'd0);
        #1;
        rst_n_i = 1'b1;
        wb.writeback_ready_i = 1'b1;
        repeat (3) step();
        check("arst_fifo_empty", 64'(wb.valid_o), 64'd0);
        check("final_q_empty", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
